// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount controller.
// State encoding and byte width live here so every unit agrees on them.
package popcount_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/popcount_int8.sv
// Combinational population count of one byte.
// Result range is 0..8, so four bits are enough.
module popcount_int8 (
  input  logic [7:0] a,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y = y + {3'b000, a[i]};
    end
  end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Byte-serial popcount: one popcount_int8 is reused across all bytes.
// IDLE accepts a vector, RUN consumes a byte per cycle, DONE holds result.
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int EARLY_EXIT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               init_q;
  logic [3:0]         byte_cnt;
  logic [WIDTH-1:0]   sh_nxt;
  logic               last_byte;
  logic               accept;

  popcount_int8 u_pc (
    .a (sh_q[BYTE_W-1:0]),
    .y (byte_cnt)
  );

  assign sh_nxt = sh_q >> BYTE_W;

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1)) ||
                     ((EARLY_EXIT != 0) && (sh_nxt == '0));

  // init_q keeps in_ready low while reset is held and for the
  // remainder of that cycle; it rises on the first edge after release.
  assign in_ready  = init_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_count = out_valid ? acc_q : '0;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + CNT_W'(byte_cnt);
        sh_d  = sh_nxt;
        idx_d = idx_q + IDX_W'(1);
        if (last_byte) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Bench for popcount_seq_ctrl: one instance without and one with early exit.
// Expected counts and latencies come from a byte-level reference model.
module tb_popcount_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [63:0] in_data  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [6:0] out_count [2];
  logic       busy      [2];

  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.WIDTH(64), .EARLY_EXIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_count (out_count[0]),
    .busy      (busy[0])
  );

  popcount_seq_ctrl #(.WIDTH(64), .EARLY_EXIT(1)) dut_ee (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_count (out_count[1]),
    .busy      (busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_count(input logic [63:0] d);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(d[i]);
    return n;
  endfunction

  // Cycles from acceptance to out_valid: all bytes, or up to the highest
  // non-zero byte when early exit is enabled (at least one cycle).
  function automatic int ref_lat(input int ee, input logic [63:0] d);
    int hi = 0;
    if (ee == 0) return 8;
    for (int b = 0; b < 8; b++) begin
      if (((d >> (8 * b)) & 64'hFF) != 0) hi = b;
    end
    return hi + 1;
  endfunction

  task automatic idle_all();
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      in_data[s]   = '0;
    end
  endtask

  task automatic run_vec(input int s, input logic [63:0] d, input int hold,
                         input string tag);
    int cyc;
    int lat;
    logic [6:0] held;
    lat = ref_lat(s, d);
    cyc = 0;
    while (!in_ready[s] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, ".in_ready"}, in_ready[s], 1'b1);
    in_valid[s]  = 1'b1;
    in_data[s]   = d;
    out_ready[s] = (hold == 0);
    tick();
    in_valid[s] = 1'b0;
    cyc = 0;
    while (!out_valid[s] && cyc < 50) begin
      chk({tag, ".run_cnt0"}, out_count[s], 7'd0);
      in_data[s] = {$urandom, $urandom};
      in_valid[s] = 1'($urandom);
      tick();
      cyc++;
    end
    in_valid[s] = 1'b0;
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".count"}, out_count[s], ref_count(d));
    held = out_count[s];
    for (int h = 0; h < hold; h++) begin
      in_valid[s] = 1'b1;
      in_data[s]  = {$urandom, $urandom};
      tick();
      chk({tag, ".bp_valid"}, out_valid[s], 1'b1);
      chk({tag, ".bp_stable"}, out_count[s], held);
      chk({tag, ".bp_ready"}, in_ready[s], 1'b0);
    end
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
    chk({tag, ".post_valid"}, out_valid[s], 1'b0);
    chk({tag, ".post_busy"}, busy[s], 1'b0);
    chk({tag, ".post_ready"}, in_ready[s], 1'b1);
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] mask;
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst.in_ready", in_ready[s], 1'b0);
      chk("rst.out_valid", out_valid[s], 1'b0);
      chk("rst.out_count", out_count[s], 7'd0);
      chk("rst.busy", busy[s], 1'b0);
    end
    rst_n = 1'b1;
    chk("rel.in_ready_low", in_ready[0], 1'b0);
    tick();
    chk("rel.in_ready", in_ready[0], 1'b1);
    chk("rel.in_ready_ee", in_ready[1], 1'b1);
    chk("rel.out_valid", out_valid[0], 1'b0);

    run_vec(0, 64'hFFFF_0000_0F0F_0001, 0, "basic");
    run_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "ones");
    run_vec(0, 64'h0, 0, "zero");
    run_vec(1, 64'h0000_0000_0000_0300, 0, "ee_0300");
    run_vec(1, 64'h0, 0, "ee_zero");
    run_vec(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "ee_ones");
    run_vec(0, 64'h8000_0000_0000_0001, 5, "bp");

    // Reset pulse while the plain instance is mid-vector (index 3).
    in_valid[0] = 1'b1;
    in_data[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("mid.busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy_rst", busy[0], 1'b0);
    chk("mid.ready_rst", in_ready[0], 1'b0);
    chk("mid.count_rst", out_count[0], 7'd0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mid.no_valid", out_valid[0], 1'b0);
    end
    chk("mid.idle_ready", in_ready[0], 1'b1);
    run_vec(0, 64'h1, 0, "mid.next");

    for (int n = 0; n < 24; n++) begin
      mask = 64'hFFFF_FFFF_FFFF_FFFF >> (8 * $urandom_range(0, 7));
      d = {$urandom, $urandom} & mask;
      if ($urandom_range(0, 5) == 0) d = '0;
      run_vec(n % 2, d, $urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/popcount_seq_ctrl.md
POPCOUNT_SEQ_CTRL -- requirements
Module: popcount_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning input vector width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter EARLY_EXIT, default 0, meaning 1 enables termination once the remaining bytes are all zero.
REQ-003 SHALL have localparam NBYTES = WIDTH/8 and localparam CNT_W = $clog2(WIDTH+1).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL provide port in_valid, input, 1 bit: the source presents a vector.
REQ-007 SHALL provide port in_ready, output, 1 bit: the block can accept a vector.
REQ-008 SHALL provide port in_data, input, WIDTH bits: the vector to count.
REQ-009 SHALL provide port out_valid, output, 1 bit: out_count is valid.
REQ-010 SHALL provide port out_ready, input, 1 bit: the sink accepts the result.
REQ-011 SHALL provide port out_count, output, CNT_W bits: number of set bits in the accepted vector.
REQ-012 SHALL provide port busy, output, 1 bit: high in the RUN or DONE state.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, and SHALL drive out_valid = 1 only in DONE (both registered or state-decoded, no combinational path from inputs).
REQ-015 IDLE SHALL accept on in_valid & in_ready: load in_data into a WIDTH-bit shift register, clear the accumulator, clear the byte index, and go to RUN.
REQ-016 Each RUN cycle SHALL add the 8-bit popcount of shift_reg[7:0] (range 0..8, zero-extended to CNT_W) into the accumulator, shift the register right by 8, and increment the index.
REQ-017 RUN SHALL go to DONE on the edge that processes byte index NBYTES-1.
REQ-018 With acceptance on edge E0, out_valid SHALL first be high after edge E(NBYTES), i.e. a latency of NBYTES cycles.
REQ-019 When EARLY_EXIT=1, RUN SHALL go to DONE on the edge where the post-shift register is all zero, with the accumulator already including the current byte.
REQ-020 When EARLY_EXIT=1 and an all-zero vector is accepted, the block SHALL reach DONE after 1 RUN cycle with count 0.
REQ-021 DONE SHALL hold out_count and out_valid stable until out_ready=1, then SHALL return to IDLE on that edge.
REQ-022 There SHALL be no IDLE bypass: a new vector is accepted no earlier than the cycle after the output handshake.
REQ-023 The accumulator SHALL never overflow: its maximum value is WIDTH, and CNT_W bits are sufficient.
REQ-024 in_data changes while not in IDLE SHALL have no effect.
REQ-025 out_count SHALL read 0 in every state other than DONE.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force state=IDLE, shift register=0, accumulator=0 and index=0.
REQ-027 During reset the outputs SHALL be in_ready=0, out_valid=0, out_count=0 and busy=0.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation and discard any pending result; no out_valid follows.

Structure
REQ-030 State encoding and a byte-width constant of 8 SHALL live in shared package popcount_pkg; WIDTH and EARLY_EXIT remain module parameters.
REQ-031 The per-byte count SHALL instantiate the existing 8-bit combinational popcount sub-module popcount_int8, using Y[3:0].
REQ-032 Only one popcount_int8 instance SHALL exist, time-shared across all bytes; this is the resource being sequenced.

Verification
REQ-033 Reset: WIDTH=64, apply rst_n=0 -> 1 -> in_ready=1 next cycle, and out_valid=0, busy=0, out_count=0.
REQ-034 Basic count: WIDTH=64, in_data=64'hFFFF_0000_0F0F_0001 with out_ready=1 -> out_valid exactly 8 cycles after acceptance with out_count=25, then in_ready=1 the following cycle.
REQ-035 Extremes: in_data=all ones -> out_count=64; in_data=0 with EARLY_EXIT=0 -> out_count=0 after 8 cycles.
REQ-036 Early exit: EARLY_EXIT=1, in_data=64'h0000_0000_0000_0300 -> out_valid after 2 cycles with out_count=2.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_count stable, in_ready=0 and in_valid ignored; then out_ready=1 -> IDLE on the next edge.
REQ-038 Mid-operation reset: pulse rst_n low during RUN at index 3 -> IDLE, no out_valid; the next vector 64'h1 -> count 1.
